// File: rtl/rv_mem_arb_pkg.sv
// rv_mem_arb_pkg: shared types and defaults for the memory arbiter
package rv_mem_arb_pkg;
  typedef logic [31:0] u32_t;
  typedef logic [7:0] u8_t;
  typedef logic [3:0] u4_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;
  localparam int MEM_ARB_WAIT_DEF = 4;
endpackage

// File: rtl/rv_mem_arb_perf.sv
// rv_mem_arb_perf: free-running grant/conflict counters, wrapping at 2^32
module rv_mem_arb_perf
  import rv_mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   xreset,
  input  grant_t gnt,
  input  logic   conf,
  output u32_t   perf_dgnt,
  output u32_t   perf_ignt,
  output u32_t   perf_conf
);
  always_ff @(posedge clk) begin
    if (!xreset) begin
      perf_dgnt <= '0;
      perf_ignt <= '0;
      perf_conf <= '0;
    end else begin
      perf_dgnt <= perf_dgnt + 32'(gnt == GNT_D);
      perf_ignt <= perf_ignt + 32'(gnt == GNT_I);
      perf_conf <= perf_conf + 32'(conf);
    end
  end
endmodule

// File: rtl/rv_mem_arb.sv
// rv_mem_arb: fetch/data arbiter onto a 1-cycle-latency single-port RAM
// Define MEM_ARB_PERF_EN to build the performance counters; otherwise perf_* read 0.
module rv_mem_arb
  import rv_mem_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int MAX_WAIT = MEM_ARB_WAIT_DEF
) (
  input  logic          clk,
  input  logic          xreset,
  input  logic          i_req,
  input  logic [AW-1:0] i_adr,
  output logic          i_ack,
  output logic          i_rdy,
  output u32_t          i_rdata,
  input  logic          d_req,
  input  u4_t           d_we,
  input  logic [AW-1:0] d_adr,
  input  u32_t          d_wdata,
  output logic          d_ack,
  output logic          d_rdy,
  output u32_t          d_rdata,
  output logic          m_en,
  output u4_t           m_we,
  output logic [AW-1:0] m_adr,
  output u32_t          m_wdata,
  input  u32_t          m_rdata,
  output u32_t          perf_dgnt,
  output u32_t          perf_ignt,
  output u32_t          perf_conf
);
  grant_t        gnt, pend;
  logic [3:0]    wcnt;
  logic          force_i;
  logic [AW-1:0] adr_q;
  u32_t          wdata_q, i_hold, d_hold;
  assign force_i = wcnt == 4'(MAX_WAIT);
  // data wins conflicts unless fetch has already lost MAX_WAIT times in a row
  assign gnt = !xreset ? GNT_NONE :
               (d_req && !(i_req && force_i)) ? GNT_D :
               i_req ? GNT_I : GNT_NONE;
  assign i_ack   = gnt == GNT_I;
  assign d_ack   = gnt == GNT_D;
  assign m_en    = gnt != GNT_NONE;
  assign m_we    = d_ack ? d_we : '0;
  assign m_adr   = !xreset ? '0 : d_ack ? d_adr : i_ack ? i_adr : adr_q;
  assign m_wdata = !xreset ? '0 : m_en ? d_wdata : wdata_q;
  assign i_rdy   = xreset && pend == GNT_I;
  assign d_rdy   = xreset && pend == GNT_D;
  assign i_rdata = i_rdy ? m_rdata : i_hold;
  assign d_rdata = d_rdy ? m_rdata : d_hold;
  always_ff @(posedge clk) begin
    if (!xreset) begin
      wcnt    <= '0;
      pend    <= GNT_NONE;
      adr_q   <= '0;
      wdata_q <= '0;
      i_hold  <= '0;
      d_hold  <= '0;
    end else begin
      wcnt    <= (i_req && !i_ack) ? (force_i ? wcnt : wcnt + 4'd1) : 4'd0;
      pend    <= gnt;
      adr_q   <= m_adr;
      wdata_q <= m_wdata;
      i_hold  <= i_rdata;
      d_hold  <= d_rdata;
    end
  end
`ifdef MEM_ARB_PERF_EN
  rv_mem_arb_perf u_perf (
    .clk      (clk),
    .xreset   (xreset),
    .gnt      (gnt),
    .conf     (i_req && d_req),
    .perf_dgnt(perf_dgnt),
    .perf_ignt(perf_ignt),
    .perf_conf(perf_conf)
  );
`else
  assign perf_dgnt = '0;
  assign perf_ignt = '0;
  assign perf_conf = '0;
`endif
endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb: vector table plus scoreboard against a behavioural RAM
module tb_rv_mem_arb;
  import rv_mem_arb_pkg::*;
  localparam int AW = 16;
`ifdef MEM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, xreset = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0;
  logic [AW-1:0] i_adr = '0, d_adr = '0;
  u4_t d_we = '0;
  u32_t d_wdata = '0;
  logic i_ack, i_rdy, d_ack, d_rdy, m_en;
  u32_t i_rdata, d_rdata, m_wdata, m_rdata, perf_dgnt, perf_ignt, perf_conf;
  u4_t m_we;
  logic [AW-1:0] m_adr;
  rv_mem_arb #(.AW(AW), .MAX_WAIT(4)) dut (
    .clk(clk), .xreset(xreset),
    .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdy(d_rdy), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .perf_dgnt(perf_dgnt), .perf_ignt(perf_ignt), .perf_conf(perf_conf)
  );
  always #5 clk = ~clk;
  u32_t ram [256];
  u32_t ref_mem [256];
  always @(posedge clk) begin
    if (m_en) begin
      m_rdata <= ram[m_adr[7:0]];
      for (int b = 0; b < 4; b++)
        if (m_we[b]) ram[m_adr[7:0]][8*b+:8] <= m_wdata[8*b+:8];
    end
  end
  typedef struct {
    grant_t g;
    logic   chk;
    u32_t   data;
  } exp_t;
  typedef struct {
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    u4_t           we;
    logic [AW-1:0] da;
    u32_t          wd;
    grant_t        eg;
  } vec_t;
  exp_t sbq[$];
  vec_t tbl[$];
  int tests = 0, fails = 0;
  u32_t last_i;
  logic last_i_ok = 1'b0;
  task automatic check(input string name, input u32_t act, input u32_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drain();
    exp_t e;
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    check("i_rdy", 32'(i_rdy), 32'(e.g == GNT_I));
    check("d_rdy", 32'(d_rdy), 32'(e.g == GNT_D));
    if (e.g == GNT_I) begin
      check("i_rdata", i_rdata, e.data);
      last_i = e.data;
      last_i_ok = 1'b1;
    end else if (last_i_ok) check("i_rdata_hold", i_rdata, last_i);
    if (e.g == GNT_D && e.chk) check("d_rdata", d_rdata, e.data);
  endtask
  task automatic cyc(input logic ir, input logic [AW-1:0] ia, input logic dr, input u4_t we,
                     input logic [AW-1:0] da, input u32_t wd, input grant_t eg);
    exp_t e;
    drain();
    i_req = ir; i_adr = ia; d_req = dr; d_we = we; d_adr = da; d_wdata = wd;
    #1;
    check("i_ack", 32'(i_ack), 32'(eg == GNT_I));
    check("d_ack", 32'(d_ack), 32'(eg == GNT_D));
    check("m_en", 32'(m_en), 32'(eg != GNT_NONE));
    if (eg != GNT_NONE) begin
      check("m_we", 32'(m_we), eg == GNT_D ? 32'(we) : 32'd0);
      check("m_adr", 32'(m_adr), eg == GNT_D ? 32'(da) : 32'(ia));
    end
    e.g = eg;
    e.chk = eg == GNT_I || (eg == GNT_D && we == 4'd0);
    e.data = eg == GNT_I ? ref_mem[ia[7:0]] : ref_mem[da[7:0]];
    if (eg == GNT_D)
      for (int b = 0; b < 4; b++)
        if (we[b]) ref_mem[da[7:0]][8*b+:8] = wd[8*b+:8];
    sbq.push_back(e);
    @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    xreset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = '0;
    repeat (n) @(negedge clk);
    sbq.delete();
    last_i_ok = 1'b0;
    xreset = 1'b1;
  endtask
  task automatic check_perf(input string tag, input u32_t d, input u32_t i, input u32_t c);
    check({tag, "_dgnt"}, perf_dgnt, PERF ? d : 32'd0);
    check({tag, "_ignt"}, perf_ignt, PERF ? i : 32'd0);
    check({tag, "_conf"}, perf_conf, PERF ? c : 32'd0);
  endtask
  initial begin
    logic [AW-1:0] ia, da;
    grant_t eg;
    for (int k = 0; k < 256; k++) begin
      ram[k] = 32'hC0DE0000 + u32_t'(k) * 32'h00010003;
      ref_mem[k] = ram[k];
    end
    for (int k = 0; k < 8; k++)
      tbl.push_back('{1'b1, AW'(k), 1'b0, 4'h0, '0, 32'd0, GNT_I});
    tbl.push_back('{1'b0, '0, 1'b1, 4'hF, 16'h10, 32'hDEADBEEF, GNT_D});
    tbl.push_back('{1'b0, '0, 1'b1, 4'h0, 16'h10, 32'd0, GNT_D});
    tbl.push_back('{1'b0, '0, 1'b1, 4'h1, 16'h10, 32'h00000055, GNT_D});
    tbl.push_back('{1'b0, '0, 1'b1, 4'h0, 16'h10, 32'd0, GNT_D});
    tbl.push_back('{1'b1, 16'h10, 1'b0, 4'h0, '0, 32'd0, GNT_I});
    tbl.push_back('{1'b1, 16'h11, 1'b1, 4'hF, 16'h11, 32'h12345678, GNT_D});
    tbl.push_back('{1'b1, 16'h11, 1'b0, 4'h0, '0, 32'd0, GNT_I});
    tbl.push_back('{1'b0, '0, 1'b0, 4'h0, '0, 32'd0, GNT_NONE});
    tbl.push_back('{1'b0, '0, 1'b0, 4'h0, '0, 32'd0, GNT_NONE});
    @(negedge clk);
    // requests during reset must not leak to the memory
    i_req = 1'b1; d_req = 1'b1; d_we = 4'hF;
    repeat (3) begin
      #1;
      check("rst_i_ack", 32'(i_ack), 32'd0);
      check("rst_d_ack", 32'(d_ack), 32'd0);
      check("rst_m_en", 32'(m_en), 32'd0);
      check("rst_m_we", 32'(m_we), 32'd0);
      @(negedge clk);
    end
    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, '0, 1'b0, 4'h0, '0, 32'd0, GNT_NONE);
      check("idle_i_rdy", 32'(i_rdy), 32'd0);
      check("idle_d_rdy", 32'(d_rdy), 32'd0);
    end
    check_perf("idle", 32'd0, 32'd0, 32'd0);
    foreach (tbl[k])
      cyc(tbl[k].ir, tbl[k].ia, tbl[k].dr, tbl[k].we, tbl[k].da, tbl[k].wd, tbl[k].eg);
    check("byte_merge_rd", ram[8'h10], 32'hDEADBE55);
    do_reset(2);
    ia = 16'h0; da = 16'h20;
    for (int k = 0; k < 20; k++) begin
      eg = (k % 5 == 4) ? GNT_I : GNT_D;
      cyc(1'b1, ia, 1'b1, 4'h0, da, 32'd0, eg);
      if (eg == GNT_I) ia++; else da++;
    end
    check_perf("conf", 32'd16, 32'd4, 32'd20);
    cyc(1'b0, '0, 1'b0, 4'h0, '0, 32'd0, GNT_NONE);
    cyc(1'b1, 16'h3, 1'b0, 4'h0, '0, 32'd0, GNT_I);
    sbq.delete();
    xreset = 1'b0; i_req = 1'b0;
    #1 check("mid_rst_i_rdy", 32'(i_rdy), 32'd0);
    @(negedge clk);
    xreset = 1'b1;
    #1 check("post_rst_i_rdy", 32'(i_rdy), 32'd0);
    check_perf("post_rst", 32'd0, 32'd0, 32'd0);
    cyc(1'b1, 16'h5, 1'b0, 4'h0, '0, 32'd0, GNT_I);
    cyc(1'b0, '0, 1'b0, 4'h0, '0, 32'd0, GNT_NONE);
    cyc(1'b0, '0, 1'b0, 4'h0, '0, 32'd0, GNT_NONE);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Arbitrates the core's instruction-fetch port and data-access port onto one single-port synchronous RAM, which has 1-cycle registered read latency.
- Sits between rv_core and the program/data BRAM inside rvc.
- Pipelined: one grant per cycle; data access normally wins conflicts.
- A starvation limiter guarantees fetch progress.

Parameters:
- AW, 16, word-address width of memory port (bytes = 4·2^AW)
- MAX_WAIT, 4, consecutive cycles fetch may lose before it is forced to win (1..15)

Ports:
- clk  in  1  system clock
- xreset  in  1  synchronous active-low reset
- i_req  in  1  fetch request
- i_adr  in  AW  fetch word address
- i_ack  out  1  fetch granted this cycle (combinational); requester may change i_adr next cycle
- i_rdy  out  1  i_rdata valid (cycle after i_ack)
- i_rdata  out  32  fetch data
- d_req  in  1  data request
- d_we  in  4  byte write enables; 0 = read
- d_adr  in  AW  data word address
- d_wdata  in  32  write data
- d_ack  out  1  data granted this cycle (combinational)
- d_rdy  out  1  data access complete; d_rdata valid if it was a read
- d_rdata  out  32  read data
- m_en  out  1  memory enable
- m_we  out  4  memory byte write enables
- m_adr  out  AW  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid the cycle after m_en
- perf_dgnt, perf_ignt, perf_conf  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (xreset=0 at posedge):
  - wait counter = 0; pending-grant register cleared.
  - i_rdy = d_rdy = 0.
  - perf counters = 0.
  - Combinational outputs follow the inputs but are gated to 0 while xreset=0.
- Grant selection each cycle, combinational:
  - Neither requesting: no grant; m_en = 0; m_we = 0; m_adr/m_wdata hold their last values (don't-care).
  - One requesting: that one is granted.
  - Both requesting: d wins, unless wait counter == MAX_WAIT, in which case i wins.
- Memory drive on grant:
  - m_en = 1; m_adr comes from the granted port.
  - m_we = d_we for a d grant, 0 for an i grant; m_wdata = d_wdata.
- Wait counter, 4-bit:
  - Increments when i_req=1 and i not granted; saturates at MAX_WAIT.
  - Clears on i grant or when i_req=0.
- Pending register records which port was granted in cycle N.
- Cycle N+1: the owner's rdy = 1 and its rdata = m_rdata.
  - The other port's rdy = 0; its rdata holds its last valid value.
  - d_rdy asserts for writes too.
- Back-to-back grants are allowed. A grant in N+1 overlaps the rdy of N; no bubble.
- A request must stay asserted, with stable address, until ack. After ack, a req still high in the next cycle is treated as a new request.
- Reset asserted mid-access: pending grant discarded; no rdy in the first cycle after xreset rises.
- d_adr == i_adr in the same cycle: no special case. Sequential grants order the write before the fetch.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: three free-running 32-bit counters, wrapping at 2^32.
  - perf_dgnt increments on each d grant.
  - perf_ignt increments on each i grant.
  - perf_conf increments on each cycle with i_req & d_req.
- Undefined: counters not instantiated; perf_* tied to 0. Ports stay present, so the interface is unchanged.

Decomposition:
- Shared package (rv_types.svh):
  - u32_t and u8_t are already present.
  - Add grant_t enum {GNT_NONE, GNT_I, GNT_D}.
  - Add byte-enable typedef u4_t.
  - Add constant MEM_ARB_WAIT_DEF = 4.
- One natural sub-module: rv_mem_arb_perf, holding the three counters. It is instantiated only under MEM_ARB_PERF_EN.

Test Plan:
- Reset then idle (i_req = d_req = 0 for 10 cycles) -> m_en = 0, i_rdy = d_rdy = 0, perf_* = 0.
- i_req=1 streaming addresses 0x0..0x7 with d idle -> i_ack every cycle; i_rdy every cycle from cycle 2; i_rdata matches preloaded RAM words at addresses 0..7.
- d write d_we=4'hF, d_adr=0x10, d_wdata=0xDEADBEEF, then d read at 0x10 -> write: d_ack, then d_rdy next cycle. Read: d_rdy with d_rdata = 0xDEADBEEF. Byte write d_we=4'h1, d_wdata=0x55 then read -> 0xDEADBE55.
- Both requesting continuously, MAX_WAIT=4 -> grant pattern D,D,D,D,I repeating; perf_conf = cycle count; perf_dgnt:perf_ignt = 4:1.
- xreset pulled low for one cycle directly after an i grant -> no i_rdy in the cycle after xreset rises; first grant after reset proceeds normally.
- Build without MEM_ARB_PERF_EN, repeat the conflict test -> identical grant pattern; perf_* constant 0.
